// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/ack bus and downstream valid/ready instruction bus.
// The master modport is the fetch stage; the slave modport is memory plus the consumer.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, instr_ready
    );
    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning the PC; one req/ack fetch at a time, valid/ready output.
// Define FETCH_ALIGN_CHK_EN for the sticky misaligned-PC trap (ALIGN_ERR and absorbing ERROR state).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_next_pc,
    input  logic        i_redirect,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_align_err,
    fetch_unit_if.master bus
);
`ifdef FETCH_ALIGN_CHK_EN
    typedef enum logic [1:0] {ISSUE, REQ, HOLD, ERROR} state_t;
`else
    typedef enum logic [1:0] {ISSUE, REQ, HOLD} state_t;
`endif
    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc, r_addr, w_addr, r_instr, w_instr, r_instr_pc, w_instr_pc, w_pc_load;
    logic        r_kill, w_kill, r_req, r_valid, w_load;
    assign o_pc            = r_pc;
    assign o_pc_plus4      = r_pc + 32'd4;
    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = r_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_valid;
`ifdef FETCH_ALIGN_CHK_EN
    logic r_align_err, w_misalign;
    assign w_pc_load   = i_next_pc;
    assign w_misalign  = |i_next_pc[1:0];
    assign o_align_err = r_align_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_align_err <= 1'b0;
        else if (w_load && w_misalign) r_align_err <= 1'b1;
    end
`else
    assign w_pc_load   = i_next_pc & ~32'd3;
    assign o_align_err = 1'b0;
`endif
    // A request already on the bus cannot be cancelled: a redirect arms r_kill and the ack drains it.
    always_comb begin
        w_state    = r_state;
        w_pc       = r_pc;
        w_addr     = r_addr;
        w_kill     = r_kill;
        w_instr    = r_instr;
        w_instr_pc = r_instr_pc;
        w_load     = 1'b0;
        case (r_state)
            ISSUE: begin
                w_addr  = r_pc;
                w_state = REQ;
            end
            REQ: begin
                if (bus.imem_ack) begin
                    w_kill = 1'b0;
                    w_load = i_redirect;
                    if (!r_kill && !i_redirect) begin
                        w_instr    = bus.imem_rdata;
                        w_instr_pc = r_addr;
                        w_state    = HOLD;
                    end else begin
                        w_state = ISSUE;
                    end
                end else if (i_redirect) begin
                    w_load = 1'b1;
                    w_kill = 1'b1;
                end
            end
            HOLD: begin
                if (i_redirect || bus.instr_ready) begin
                    w_load  = 1'b1;
                    w_state = ISSUE;
                end
            end
            default: ;
        endcase
        if (w_load) w_pc = w_pc_load;
`ifdef FETCH_ALIGN_CHK_EN
        if (w_state == ISSUE && (r_align_err || (w_load && w_misalign))) w_state = ERROR;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ISSUE;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_kill     <= 1'b0;
            r_instr    <= 32'd0;
            r_instr_pc <= 32'd0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_pc       <= w_pc;
            r_addr     <= w_addr;
            r_kill     <= w_kill;
            r_instr    <= w_instr;
            r_instr_pc <= w_instr_pc;
            r_req      <= w_state == REQ;
            r_valid    <= w_state == HOLD;
        end
    end
endmodule
